stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input and on the output.
- Successor to the gate-level 2:1 mux. Channel selection is internal (round-robin or fixed priority) instead of an external SEL.
- Sits between multiple producers and one shared consumer. Carries single-beat transfers and reports which channel each beat came from.

Parameters:
- N_CH, 4, number of input channels (legal 2..16)
- WIDTH, 8, data bits per channel
- MODE, 0, arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- IN_VALID  input  N_CH  per-channel valid
- IN_DATA  input  N_CH*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH]
- IN_READY  output  N_CH  per-channel ready (combinational)
- OUT_VALID  output  1  output register holds a beat
- OUT_DATA  output  WIDTH  registered data
- OUT_CH  output  CH_W  source channel of OUT_DATA; CH_W = max(1, clog2(N_CH))
- OUT_READY  input  1  consumer ready

Behaviour:
- Reset (RST_N low, asynchronous): OUT_VALID=0, OUT_DATA=0, OUT_CH=0, RR pointer LAST=N_CH-1. IN_READY reads 0 while RST_N is low.
- Output register states: EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
- load_en = !OUT_VALID | OUT_READY. The register may load when empty or when being drained in the same cycle.
- Grant (combinational, one-hot, at most one bit):
  - MODE=0: first i with IN_VALID[i]=1, searching from (LAST+1) mod N_CH upward with wrap.
  - MODE=1: lowest i with IN_VALID[i]=1.
- IN_READY[i] = grant[i] & load_en. Never asserted for a channel whose IN_VALID is 0.
- Transfer in: IN_VALID[i] & IN_READY[i]. On that edge OUT_DATA<=IN_DATA[i], OUT_CH<=i, OUT_VALID<=1, LAST<=i (MODE=0 only).
- Transfer out: OUT_VALID & OUT_READY.
- Simultaneous in and out: the register reloads back-to-back with no bubble, giving 1 beat/cycle throughput.
- Out without in: OUT_VALID<=0, and OUT_DATA/OUT_CH hold their last values.
- Latency: 1 cycle from input handshake to OUT_VALID.
- When FULL and !OUT_READY: all IN_READY=0, and OUT_DATA/OUT_CH stay stable until accepted (AXI-style hold).
- LAST updates only on an accepted input transfer. Stall cycles do not advance the pointer.
- Fairness, MODE=0: with all channels continuously valid and OUT_READY=1, grants cycle 0,1,...,N_CH-1,0 (first grant after reset is channel 0).
- Wrap: from LAST=N_CH-1 the search starts at 0.
- No valid inputs: no grant; OUT_VALID falls after the held beat drains.
- Reset mid-operation: a held beat is discarded and LAST returns to N_CH-1. No partial state survives.
- Producers must hold IN_DATA stable while IN_VALID=1 and not yet accepted. The block does not check this.

Decomposition:
- Shared package mux_pkg:
  - function clog2
  - localparam ARB_RR=0, ARB_FIXED=1
  - CH_W derivation rule
- One sub-module is natural: rr_arbiter (params N_CH, MODE; inputs CLK, RST_N, REQ[N_CH], ADV; outputs GNT[N_CH] one-hot, GNT_IDX[CH_W]). It owns the LAST pointer and advances only when ADV is asserted.
- The top level holds the output register and data muxing.

Test Plan:
- Reset check: assert RST_N=0 mid-stream with OUT_VALID=1 -> OUT_VALID=0, OUT_DATA=0, OUT_CH=0 immediately. After release with IN_VALID=4'b1111, the first OUT_CH=0.
- RR fairness: N_CH=4, all valid, IN_DATA ch i = 8'hA0+i, OUT_READY=1 for 8 cycles -> OUT_CH sequence 0,1,2,3,0,1,2,3 and OUT_DATA A0..A3 repeating, one beat per cycle.
- Backpressure: load ch2=8'h5C, hold OUT_READY=0 for 5 cycles -> OUT_VALID=1, OUT_DATA=5C, OUT_CH=2 stable, IN_READY=0. On OUT_READY=1 the next beat loads in the same cycle.
- Sparse requests and wrap: LAST=3, only ch1 and ch3 valid -> grant ch1, then ch3, then ch1.
- Fixed priority (MODE=1): ch0 and ch3 continuously valid -> ch0 granted every cycle and ch3 never gets IN_READY. Drop ch0 -> ch3 is granted next cycle.
- Idle drain: single beat on ch1=8'h11, then no valid -> OUT_VALID high one cycle (OUT_READY=1), then 0 with OUT_DATA holding 11.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the stream mux family.
//   ARB_RR / ARB_FIXED : arbitration mode encodings
//   clog2()            : ceiling log2 used for parameter derivation
//   ch_w()             : channel-index width, never below 1 bit
package mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // A 1-channel index still needs one bit to exist as a port.
  function automatic int ch_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter with round-robin or fixed-priority selection.
//   clk, rst_n : clock, async active-low reset
//   req        : per-channel request
//   adv        : a grant was accepted this cycle; move the RR pointer
//   gnt        : one-hot grant (all zero when no request)
//   gnt_idx    : binary index of the granted channel
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int MODE = ARB_RR,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            adv,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx
);

  // Most recently accepted channel; search starts just above it.
  logic [CH_W-1:0] last;

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (MODE == ARB_RR) idx = (int'(last) + 1 + k) % N_CH;
      else                idx = k;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = CH_W'(idx);
      end
    end
  end

  // Reset to N_CH-1 so the first search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        last <= CH_W'(N_CH - 1);
    else if (adv && MODE == ARB_RR)    last <= gnt_idx;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output
// stage. Arbitration picks one producer per cycle; the output register
// reloads back-to-back while draining, giving one beat per cycle.
//   clk, rst_n : clock, async active-low reset
//   in_valid   : per-channel valid
//   in_data    : flattened data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   : per-channel ready (combinational)
//   out_valid  : output register holds a beat
//   out_data   : registered beat
//   out_ch     : source channel of out_data
//   out_ready  : consumer ready
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = ARB_RR,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready
);

  logic [N_CH-1:0][WIDTH-1:0] in_lane;
  logic [N_CH-1:0]            gnt;
  logic [CH_W-1:0]            gnt_idx;
  logic                       load_en;
  logic                       xfer_in;

  assign in_lane = in_data;

  // Register may take a beat when empty or when its beat leaves this cycle.
  assign load_en  = !out_valid || out_ready;
  // Gating with rst_n keeps ready low throughout reset.
  assign in_ready = gnt & {N_CH{load_en & rst_n}};
  assign xfer_in  = |in_ready;

  rr_arbiter #(.N_CH(N_CH), .MODE(MODE)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .adv     (xfer_in),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // On drain without refill only valid drops; data/ch keep last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      out_data  <= in_lane[gnt_idx];
      out_ch    <= gnt_idx;
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic [3:0] rr_ready, fp_ready;
  logic       rr_valid, fp_valid;
  logic [7:0] rr_data, fp_data;
  logic [1:0] rr_ch, fp_ch;

  int errors = 0;
  int checks = 0;

  // reference state: index 0 = round-robin DUT, 1 = fixed-priority DUT
  int         m_vld[2];
  logic [7:0] m_data[2];
  int         m_ch[2];
  int         m_last;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_ready), .out_valid(rr_valid), .out_data(rr_data),
    .out_ch(rr_ch), .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_ready), .out_valid(fp_valid), .out_data(fp_data),
    .out_ch(fp_ch), .out_ready(out_ready)
  );

  function automatic logic [3:0] m_ready(int d);
    logic [3:0] r;
    int idx;
    r = '0;
    if (!rst_n) return r;
    if (m_vld[d] != 0 && !out_ready) return r;
    for (int k = 0; k < 4; k++) begin
      idx = (d == 0) ? (m_last + 1 + k) % 4 : k;
      if (in_valid[idx]) begin
        r[idx] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 0; m_data[d] = '0; m_ch[d] = 0;
    end
    m_last = 3;
  endtask

  task automatic model_edge();
    logic [3:0] r[2];
    for (int d = 0; d < 2; d++) r[d] = m_ready(d);
    for (int d = 0; d < 2; d++) begin
      if (r[d] != 0) begin
        for (int i = 0; i < 4; i++)
          if (r[d][i]) begin
            m_vld[d] = 1; m_data[d] = in_data[i*8 +: 8]; m_ch[d] = i;
            if (d == 0) m_last = i;
          end
      end else if (m_vld[d] == 0 || out_ready) begin
        m_vld[d] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    #1 model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_lane(int i, logic [7:0] v);
    in_data[i*8 +: 8] = v;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rr_valid !== 1'b0 || rr_data !== 8'h00 || rr_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_rr: valid=%b data=%h ch=%0d, want 0/00/0", rr_valid, rr_data, rr_ch);
    end
    checks++;
    if (fp_valid !== 1'b0 || fp_data !== 8'h00 || fp_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_fp: valid=%b data=%h ch=%0d, want 0/00/0", fp_valid, fp_data, fp_ch);
    end
    // hold a beat, then reset asynchronously between edges
    for (int i = 0; i < 4; i++) set_lane(i, 8'h30 + 8'(i));
    in_valid = 4'b1111;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (rr_valid !== 1'b1 || rr_data !== 8'h30) begin
      errors++;
      $display("FAIL reset_pre_held: valid=%b data=%h, want 1/30", rr_valid, rr_data);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (rr_valid !== 1'b0 || rr_data !== 8'h00 || rr_ch !== 2'd0 || rr_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: valid=%b data=%h ch=%0d ready=%b, want 0/00/0/0000",
               rr_valid, rr_data, rr_ch, rr_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    checks++;
    if (rr_valid !== 1'b1 || rr_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant: valid=%b ch=%0d, want 1/0", rr_valid, rr_ch);
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 8'hA0 + 8'(i));
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (rr_valid !== 1'b1 || rr_ch !== 2'(c % 4) || rr_data !== 8'hA0 + 8'(c % 4)) begin
        errors++;
        $display("FAIL rr_fair[%0d]: valid=%b ch=%0d data=%h, want 1/%0d/%h",
                 c, rr_valid, rr_ch, rr_data, c % 4, 8'hA0 + 8'(c % 4));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_lane(2, 8'h5C);
    set_lane(3, 8'h77);
    in_valid = 4'b0100;
    out_ready = 1'b0;
    tick();
    in_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rr_valid !== 1'b1 || rr_data !== 8'h5C || rr_ch !== 2'd2 || rr_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ch=%0d ready=%b, want 1/5c/2/0000",
                 c, rr_valid, rr_data, rr_ch, rr_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rr_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, want 1000", rr_ready);
    end
    tick();
    checks++;
    if (rr_valid !== 1'b1 || rr_ch !== 2'd3 || rr_data !== 8'h77) begin
      errors++;
      $display("FAIL bp_reload: valid=%b ch=%0d data=%h, want 1/3/77", rr_valid, rr_ch, rr_data);
    end
  endtask

  task automatic test_sparse_wrap();
    int exp_ch[3] = '{1, 3, 1};
    do_reset();
    in_valid = 4'b1010;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rr_valid !== 1'b1 || rr_ch !== 2'(exp_ch[c])) begin
        errors++;
        $display("FAIL sparse[%0d]: valid=%b ch=%0d, want 1/%0d", c, rr_valid, rr_ch, exp_ch[c]);
      end
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    set_lane(0, 8'h0F);
    set_lane(3, 8'h3F);
    in_valid = 4'b1001;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (fp_ready[3] !== 1'b0) begin
        errors++;
        $display("FAIL fp_starve_ready[%0d]: ready=%b, want bit3=0", c, fp_ready);
      end
      tick();
      checks++;
      if (fp_valid !== 1'b1 || fp_ch !== 2'd0 || fp_data !== 8'h0F) begin
        errors++;
        $display("FAIL fp_ch0[%0d]: valid=%b ch=%0d data=%h, want 1/0/0f", c, fp_valid, fp_ch, fp_data);
      end
    end
    in_valid = 4'b1000;
    tick();
    checks++;
    if (fp_valid !== 1'b1 || fp_ch !== 2'd3 || fp_data !== 8'h3F) begin
      errors++;
      $display("FAIL fp_ch3: valid=%b ch=%0d data=%h, want 1/3/3f", fp_valid, fp_ch, fp_data);
    end
  endtask

  task automatic test_idle_drain();
    do_reset();
    set_lane(1, 8'h11);
    in_valid = 4'b0010;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    checks++;
    if (rr_valid !== 1'b1 || rr_data !== 8'h11 || rr_ch !== 2'd1) begin
      errors++;
      $display("FAIL drain_beat: valid=%b data=%h ch=%0d, want 1/11/1", rr_valid, rr_data, rr_ch);
    end
    tick();
    checks++;
    if (rr_valid !== 1'b0 || rr_data !== 8'h11 || rr_ch !== 2'd1) begin
      errors++;
      $display("FAIL drain_empty: valid=%b data=%h ch=%0d, want 0/11/1", rr_valid, rr_data, rr_ch);
    end
  endtask

  task automatic test_random();
    logic [3:0] er, ef;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = 4'($urandom_range(0, 15));
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = m_ready(0);
      ef = m_ready(1);
      checks++;
      if (rr_ready !== er || fp_ready !== ef) begin
        errors++;
        $display("FAIL rand_ready[%0d]: rr=%b fp=%b, want rr=%b fp=%b", c, rr_ready, fp_ready, er, ef);
      end
      tick();
      checks++;
      if (rr_valid !== m_vld[0][0] || rr_data !== m_data[0] || rr_ch !== 2'(m_ch[0])) begin
        errors++;
        $display("FAIL rand_rr[%0d]: valid=%b data=%h ch=%0d, want %0d/%h/%0d",
                 c, rr_valid, rr_data, rr_ch, m_vld[0], m_data[0], m_ch[0]);
      end
      checks++;
      if (fp_valid !== m_vld[1][0] || fp_data !== m_data[1] || fp_ch !== 2'(m_ch[1])) begin
        errors++;
        $display("FAIL rand_fp[%0d]: valid=%b data=%h ch=%0d, want %0d/%h/%0d",
                 c, fp_valid, fp_data, fp_ch, m_vld[1], m_data[1], m_ch[1]);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_sparse_wrap();
    test_fixed_prio();
    test_idle_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
